// File: rtl/neuron_param_loader_pkg.sv
// rtl/neuron_param_loader_pkg.sv - shared unit types, loader state and frame-length helper
package neuron_param_loader_pkg;

  localparam int UNIT_W = 16;

  typedef logic signed [UNIT_W-1:0] unit_signed_t;

  typedef enum logic [1:0] {
    LOAD,
    FULL,
    DRAIN
  } loader_state_t;

  // Weights, then lower bound, then upper bound.
  function automatic int param_frame_len(input int n);
    return n + 2;
  endfunction

  function automatic logic unit_signed_ge(input unit_signed_t a, input unit_signed_t b);
    return a >= b;
  endfunction

endpackage

// File: rtl/neuron_param_loader_if.sv
// rtl/neuron_param_loader_if.sv - parameter word stream between sender and loader
interface neuron_param_loader_if;
  import neuron_param_loader_pkg::*;

  logic         s_valid;
  logic         s_ready;
  logic         s_last;
  unit_signed_t s_data;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/neuron_param_loader_param_bank.sv
// rtl/neuron_param_loader_param_bank.sv - register bank with indexed write, bulk load and parallel read
module neuron_param_loader_param_bank
  import neuron_param_loader_pkg::*;
#(
  parameter int DEPTH = 18,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  unit_signed_t             wr_data,
  input  logic                     load_en,
  input  unit_signed_t [DEPTH-1:0] load_data,
  output unit_signed_t [DEPTH-1:0] rd_data
);

  // Bulk load wins over a single-word write so a copy is always whole.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (load_en) begin
      rd_data <= load_data;
    end else if (wr_en) begin
      rd_data[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/neuron_param_loader.sv
// rtl/neuron_param_loader.sv - double-buffered loader for one neuron's weights and activation bounds
module neuron_param_loader
  import neuron_param_loader_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  neuron_param_loader_if.slave   stream,
  input  logic                   commit,
  output unit_signed_t [N-1:0]   weights,
  output unit_signed_t           activation_lower_bound,
  output unit_signed_t           activation_upper_bound,
  output logic                   params_valid,
  output logic                   shadow_full,
  output logic                   frame_error
);

  localparam int FRAME_LEN = param_frame_len(N);
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  loader_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic frame_error_d;
  logic params_valid_d;
  logic commit_copy;
  logic accept;
  unit_signed_t [FRAME_LEN-1:0] shadow_q;
  unit_signed_t [FRAME_LEN-1:0] active_q;

  assign stream.s_ready = !rst && (state_q != FULL);
  assign accept         = stream.s_valid && stream.s_ready;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    frame_error_d  = 1'b0;
    params_valid_d = params_valid;
    commit_copy    = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (!stream.s_last) begin
              frame_error_d = 1'b1;
              state_d       = DRAIN;
            end else if (unit_signed_ge(stream.s_data, shadow_q[N])) begin
              state_d = FULL;
            end else begin
              frame_error_d = 1'b1;
            end
          end else if (stream.s_last) begin
            frame_error_d = 1'b1;
            idx_d         = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (commit) begin
          commit_copy    = 1'b1;
          params_valid_d = 1'b1;
          state_d        = LOAD;
          idx_d          = '0;
        end
      end
      DRAIN: begin
        if (accept && stream.s_last) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      frame_error  <= 1'b0;
      params_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_error  <= frame_error_d;
      params_valid <= params_valid_d;
    end
  end

  assign shadow_full = (state_q == FULL);

  neuron_param_loader_param_bank #(.DEPTH(FRAME_LEN), .IDX_W(IDX_W)) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (accept && (state_q == LOAD)),
    .wr_idx    (idx_q),
    .wr_data   (stream.s_data),
    .load_en   (1'b0),
    .load_data ('0),
    .rd_data   (shadow_q)
  );

  neuron_param_loader_param_bank #(.DEPTH(FRAME_LEN), .IDX_W(IDX_W)) u_active (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .load_en   (commit_copy),
    .load_data (shadow_q),
    .rd_data   (active_q)
  );

  assign weights                = active_q[N-1:0];
  assign activation_lower_bound = active_q[N];
  assign activation_upper_bound = active_q[N+1];

endmodule

// File: tb/tb_neuron_param_loader.sv
// tb/tb_neuron_param_loader.sv - directed vector bench for neuron_param_loader with N=4
module tb_neuron_param_loader;
  import neuron_param_loader_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic commit = 1'b0;
  unit_signed_t [N-1:0] weights;
  unit_signed_t activation_lower_bound;
  unit_signed_t activation_upper_bound;
  logic params_valid;
  logic shadow_full;
  logic frame_error;

  neuron_param_loader_if bus ();

  neuron_param_loader #(.N(N)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .stream                 (bus),
    .commit                 (commit),
    .weights                (weights),
    .activation_lower_bound (activation_lower_bound),
    .activation_upper_bound (activation_upper_bound),
    .params_valid           (params_valid),
    .shadow_full            (shadow_full),
    .frame_error            (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic valid;
    int   data;
    logic last;
    logic commit;
    logic exp_ready;
    logic exp_full;
    logic exp_err;
    logic exp_pv;
    int   exp_set;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_bad = 0;

  // Row 0 is the reset set; rows 1..3 are frames A, B, C (w0..w3, lower, upper).
  int sets [4][6] = '{'{0, 0, 0, 0, 0, 0},
                      '{1, 2, 3, 4, -5, 7},
                      '{10, 20, 30, 40, 5, 5},
                      '{-1, -2, -3, -4, -100, 100}};

  function automatic void push(logic r, logic v, int d, logic l, logic c,
                               logic er, logic ef, logic ee, logic ep, int es);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.last = l; t.commit = c;
    t.exp_ready = er; t.exp_full = ef; t.exp_err = ee; t.exp_pv = ep; t.exp_set = es;
    vecs.push_back(t);
  endfunction

  function automatic void push_frame(int s, logic c, logic pv, int es);
    for (int k = 0; k < 6; k++)
      push(1'b0, 1'b1, sets[s][k], k == 5, c, k != 5, k == 5, 1'b0, pv, es);
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    if (act != exp) begin
      n_bad++;
      $display("FAIL vec %0d %s: got %0d, expected %0d", idx, name, act, exp);
    end
  endtask

  task automatic check_active(input int idx, input int es);
    for (int k = 0; k < N; k++)
      chk($sformatf("weights[%0d]", k), idx, int'(weights[k]), sets[es][k]);
    chk("lower", idx, int'(activation_lower_bound), sets[es][4]);
    chk("upper", idx, int'(activation_upper_bound), sets[es][5]);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    // Reset, with a stray word and commit that must be ignored.
    push(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    push(1, 1, 5, 0, 1,  0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
    // Frame A with commit held during LOAD: no effect until FULL.
    push_frame(1, 1'b1, 1'b0, 0);
    // Backpressure: valid held while FULL, nothing accepted.
    push(0, 1, 99, 0, 0,  0, 1, 0, 0, 0);
    push(0, 1, 99, 0, 0,  0, 1, 0, 0, 0);
    push(0, 1, 99, 0, 1,  1, 0, 0, 1, 1);
    push(0, 0, 0, 0, 0,   1, 0, 0, 1, 1);
    // Early s_last on word 2.
    push(0, 1, 11, 0, 0,  1, 0, 0, 1, 1);
    push(0, 1, 12, 1, 0,  1, 0, 1, 1, 1);
    push(0, 0, 0, 0, 0,   1, 0, 0, 1, 1);
    // Frame B (upper == lower), commit, commit still held in LOAD.
    push_frame(2, 1'b0, 1'b1, 1);
    push(0, 0, 0, 0, 1,   1, 0, 0, 1, 2);
    push(0, 0, 0, 0, 1,   1, 0, 0, 1, 2);
    push(0, 0, 0, 0, 0,   1, 0, 0, 1, 2);
    // Missing s_last, then three drained words.
    for (int k = 0; k < 5; k++) push(0, 1, k + 1, 0, 0, 1, 0, 0, 1, 2);
    push(0, 1, 6, 0, 0,   1, 0, 1, 1, 2);
    push(0, 1, 70, 0, 0,  1, 0, 0, 1, 2);
    push(0, 1, 71, 0, 0,  1, 0, 0, 1, 2);
    push(0, 1, 72, 1, 0,  1, 0, 0, 1, 2);
    push_frame(3, 1'b0, 1'b1, 2);
    push(0, 0, 0, 0, 1,   1, 0, 0, 1, 3);
    push(0, 0, 0, 0, 0,   1, 0, 0, 1, 3);
    // Bound check fails (lower 10, upper 3) with commit held throughout.
    for (int k = 0; k < 4; k++) push(0, 1, 0, 0, 1, 1, 0, 0, 1, 3);
    push(0, 1, 10, 0, 1,  1, 0, 0, 1, 3);
    push(0, 1, 3, 1, 1,   1, 0, 1, 1, 3);
    push(0, 0, 0, 0, 1,   1, 0, 0, 1, 3);
    push(0, 0, 0, 0, 1,   1, 0, 0, 1, 3);
    push(0, 0, 0, 0, 0,   1, 0, 0, 1, 3);
    // Reset mid-frame, then a full frame commits from word 0.
    push(0, 1, 1, 0, 0,   1, 0, 0, 1, 3);
    push(0, 1, 2, 0, 0,   1, 0, 0, 1, 3);
    push(0, 1, 3, 0, 0,   1, 0, 0, 1, 3);
    push(1, 1, 4, 0, 0,   0, 0, 0, 0, 0);
    push(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    push_frame(1, 1'b0, 1'b0, 0);
    push(0, 0, 0, 0, 1,   1, 0, 0, 1, 1);
    push(0, 0, 0, 0, 0,   1, 0, 0, 1, 1);

    foreach (vecs[i]) begin
      rst         = vecs[i].rst;
      bus.s_valid = vecs[i].valid;
      bus.s_data  = unit_signed_t'(vecs[i].data);
      bus.s_last  = vecs[i].last;
      commit      = vecs[i].commit;
      @(posedge clk);
      #1;
      n_vec++;
      chk("s_ready", i, int'(bus.s_ready), int'(vecs[i].exp_ready));
      chk("shadow_full", i, int'(shadow_full), int'(vecs[i].exp_full));
      chk("frame_error", i, int'(frame_error), int'(vecs[i].exp_err));
      chk("params_valid", i, int'(params_valid), int'(vecs[i].exp_pv));
      check_active(i, vecs[i].exp_set);
    end

    // s_ready must not follow s_valid combinationally, and must drop with rst.
    bus.s_valid = 1'b1;
    #1;
    n_vec++;
    chk("ready_valid_hi", -1, int'(bus.s_ready), 1);
    bus.s_valid = 1'b0;
    #1;
    n_vec++;
    chk("ready_valid_lo", -1, int'(bus.s_ready), 1);
    rst = 1'b1;
    #1;
    n_vec++;
    chk("ready_in_rst", -1, int'(bus.s_ready), 0);
    @(posedge clk);
    #1;
    n_vec++;
    chk("pv_after_rst", -1, int'(params_valid), 0);
    check_active(-1, 0);
    rst = 1'b0;
    #1;
    n_vec++;
    chk("ready_after_rst", -1, int'(bus.s_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
